// File: rtl/sw_mode_decoder_if.sv
// Switch-decoder bus: raw switches in, debounced word and decoded mode out.
// "slave" is the decoder side; "master" is the board/consumer side.
interface sw_mode_decoder_if;
    logic [3:0] sw;
    logic [3:0] sw_clean;
    logic [1:0] mode;
    logic       mode_valid;
    logic       fault;
    logic       mode_chg;

    modport master (output sw, input sw_clean, mode, mode_valid, fault, mode_chg);
    modport slave  (input sw, output sw_clean, mode, mode_valid, fault, mode_chg);
endinterface

// File: rtl/sw_mode_decoder.sv
// Synchronises, debounces and decodes the 4 one-hot slide switches into a 2-bit mode.
// Define SW_PRIORITY_EN to resolve multi-switch words to the lowest set bit.
module sw_mode_decoder #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    sw_mode_decoder_if.slave  bus
);

    typedef enum logic [1:0] {NONE, ONE, MULTI} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync_p0;
    logic [3:0]       sync_p1;
    logic [CNT_W-1:0] cnt;
    state_t           state;
    state_t           nxt_state;
    logic [1:0]       nxt_mode;
    logic             nxt_valid;

    function automatic state_t classify(input logic [3:0] w);
        case ($countones(w))
            0:       return NONE;
            1:       return ONE;
            default: return MULTI;
        endcase
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] w);
        if (w[0])      return 2'd0;
        else if (w[1]) return 2'd1;
        else if (w[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic valid_of(input state_t s);
`ifdef SW_PRIORITY_EN
        return s != NONE;
`else
        return s == ONE;
`endif
    endfunction

    // Stage p0/p1: two-flop synchroniser on the raw switches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= bus.sw;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: the whole word must differ from sw_clean for DEBOUNCE_CYCLES edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            bus.sw_clean <= '0;
        end else if (sync_p1 == bus.sw_clean) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            bus.sw_clean <= sync_p1;
            cnt          <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        nxt_state = classify(bus.sw_clean);
        nxt_valid = valid_of(nxt_state);
        nxt_mode  = nxt_valid ? low_index(bus.sw_clean) : 2'd0;
    end

    // Decode FSM: registered outputs follow sw_clean by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= NONE;
            bus.mode       <= 2'd0;
            bus.mode_valid <= 1'b0;
            bus.fault      <= 1'b0;
            bus.mode_chg   <= 1'b0;
        end else begin
            state          <= nxt_state;
            bus.mode       <= nxt_mode;
            bus.mode_valid <= nxt_valid;
            bus.fault      <= (nxt_state == MULTI);
            bus.mode_chg   <= {nxt_valid, nxt_mode} != {valid_of(state), bus.mode};
        end
    end

endmodule

// File: tb/tb_sw_mode_decoder.sv
// Directed and randomised bench for sw_mode_decoder against a queue-based reference model.
module tb_sw_mode_decoder;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    sw_mode_decoder_if bus ();

    sw_mode_decoder #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference state: sync stages, accepted word, and the pending mismatch samples
    logic [3:0] m_s0, m_s1, m_clean;
    logic [3:0] m_hist[$];
    logic [1:0] m_mode;
    logic       m_valid, m_fault, m_chg;

    function automatic void ref_decode(input logic [3:0] w, output logic v,
                                       output logic [1:0] m, output logic f);
        int n = 0;
        int first = -1;
        for (int i = 0; i < 4; i++)
            if (w[i]) begin
                n++;
                if (first < 0) first = i;
            end
        f = (n > 1);
`ifdef SW_PRIORITY_EN
        v = (n >= 1);
`else
        v = (n == 1);
`endif
        m = v ? 2'(first) : 2'd0;
    endfunction

    task automatic model_reset();
        m_s0 = '0; m_s1 = '0; m_clean = '0;
        m_hist.delete();
        m_mode = '0; m_valid = 1'b0; m_fault = 1'b0; m_chg = 1'b0;
    endtask

    task automatic model_edge();
        logic       v, f;
        logic [1:0] m;
        if (!rst_n) return;
        ref_decode(m_clean, v, m, f);
        m_chg   = ({v, m} != {m_valid, m_mode});
        m_valid = v; m_mode = m; m_fault = f;
        if (m_s1 == m_clean) m_hist.delete();
        else begin
            m_hist.push_back(m_s1);
            if (m_hist.size() == D) begin
                m_clean = m_s1;
                m_hist.delete();
            end
        end
        m_s1 = m_s0;
        m_s0 = bus.sw;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("sw_clean",   32'(bus.sw_clean),   32'(m_clean));
        chk("mode",       32'(bus.mode),       32'(m_mode));
        chk("mode_valid", 32'(bus.mode_valid), 32'(m_valid));
        chk("fault",      32'(bus.fault),      32'(m_fault));
        chk("mode_chg",   32'(bus.mode_chg),   32'(m_chg));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            pulses += int'(bus.mode_chg);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_clean"}, 32'(bus.sw_clean), 32'h0);
        chk({tag, "_out"}, 32'({bus.mode, bus.mode_valid, bus.fault, bus.mode_chg}), 32'h0);
    endtask

    initial begin
        int p, edges;
        logic [3:0] r;
        model_reset();

        // Reset held with a switch set: everything stays zero
        bus.sw = 4'b0010;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_hold");
        rst_n = 1'b1;
        tick();
        chk("release_no_chg", 32'(bus.mode_chg), 32'h0);
        run(4, p);
        chk("release_quiet", 32'(p), 32'h0);
        chk("release_clean_still0", 32'(bus.sw_clean), 32'h0);
        run(3, p);
        chk("release_accept_mode", 32'(bus.mode), 32'h1);
        bus.sw = 4'b0000;
        run(10, p);

        // Accept timing from a settled NONE state
        bus.sw = 4'b0010;
        run(5, p);
        chk("acc_e5_clean", 32'(bus.sw_clean), 32'h0);
        tick();
        chk("acc_e6_clean", 32'(bus.sw_clean), 32'h2);
        chk("acc_e6_chg", 32'(bus.mode_chg), 32'h0);
        tick();
        chk("acc_e7", 32'({bus.mode, bus.mode_valid, bus.mode_chg}), 32'b01_1_1);
        tick();
        chk("acc_e8_chg", 32'(bus.mode_chg), 32'h0);

        // Direct one-hot to one-hot switch
        bus.sw = 4'b1000;
        run(8, p);
        chk("dir_mode3", 32'(bus.mode), 32'h3);
        bus.sw = 4'b0001;
        run(8, p);
        chk("dir_pulses", 32'(p), 32'h1);
        chk("dir_mode0", 32'({bus.mode, bus.mode_valid}), 32'b00_1);

        // Multi-switch word: start from a state where the resolved code differs
`ifdef SW_PRIORITY_EN
        bus.sw = 4'b0000;
        run(8, p);
`endif
        bus.sw = 4'b0101;
        run(8, p);
        chk("multi_pulses", 32'(p), 32'h1);
        chk("multi_fault", 32'(bus.fault), 32'h1);
`ifdef SW_PRIORITY_EN
        chk("multi_mode", 32'({bus.mode, bus.mode_valid}), 32'b00_1);
`else
        chk("multi_mode", 32'({bus.mode, bus.mode_valid}), 32'b00_0);
`endif

        // Glitch of three cycles is rejected
        bus.sw = 4'b0000;
        run(8, p);
        bus.sw = 4'b0100;
        run(3, p);
        bus.sw = 4'b0000;
        run(10, edges);
        chk("glitch_pulses", 32'(p + edges), 32'h0);
        chk("glitch_clean", 32'(bus.sw_clean), 32'h0);

        // Reset in the middle of a debounce restarts from scratch
        bus.sw = 4'b1000;
        run(4, p);
        chk("mid_pending", 32'(m_hist.size()), 32'h2);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        while (bus.sw_clean !== 4'b1000 && edges < 20) begin
            tick();
            edges++;
        end
        chk("mid_restart_edges", 32'(edges), 32'(D + 2));

        // Randomised segments, biased toward one-hot words
        for (int s = 0; s < 250; s++) begin
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) r = 4'b0001 << $urandom_range(0, 3);
            bus.sw = r;
            run($urandom_range(1, 9), p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
